ahb_slave_mux: RTL
==================

# ahb_slave_mux

AHB read-response multiplexer and default slave sitting directly downstream of the address decoder. It takes the decoder's HSEL_RISC and HSEL_ADDER, registers them into a data-phase select, and routes the selected slave's HRDATA, HREADYOUT and HRESP back to the master. Addresses matching no slave are answered by a built-in default slave with the two-cycle AHB ERROR response. A saturating counter records decode errors for debug.

## Interface
Parameters:
- DATA_W, 32, width of all read-data buses.
- ECNT_W, 8, width of decode-error counter.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL_RISC  in  1  address-phase select from the decoder (0xC080xxxx).
- HSEL_ADDER  in  1  address-phase select from the decoder (0xC000xxxx).
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HRDATA_RISC  in  DATA_W  RISC slave read data.
- HREADYOUT_RISC  in  1  RISC slave ready.
- HRESP_RISC  in  2  RISC slave response.
- HRDATA_ADDER  in  DATA_W  adder slave read data.
- HREADYOUT_ADDER  in  1  adder slave ready.
- HRESP_ADDER  in  2  adder slave response.
- HRDATA  out  DATA_W  read data to master.
- HREADY  out  1  bus ready, also fed back to all slaves.
- HRESP  out  2  response to master (00 OKAY, 01 ERROR).
- ERR_CNT  out  ECNT_W  number of decode errors, saturating.
- ERR_CLR  in  1  synchronous clear of ERR_CNT.

## Operation
- Address phase is accepted on a rising HCLK edge where HREADY=1. Only then does the data-phase select register dsel load.
- dsel encoding: RISC, ADDER, DEFAULT (one-hot). Load value:
  - RISC if HSEL_RISC=1. RISC wins if both selects are 1.
  - Else ADDER if HSEL_ADDER=1.
  - Else DEFAULT.
- Output mux (combinational from dsel):
  - RISC / ADDER: HRDATA, HREADY and HRESP are passed through from the selected slave.
  - DEFAULT: HRDATA=0. HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=OKAY.
  - On an accepted address phase with no slave selected and HTRANS[1]=1 (NONSEQ/SEQ): go to ERR1. Otherwise stay in IDLE.
  - ERR1: HREADY=0, HRESP=ERROR. Unconditionally go to ERR2 next cycle.
  - ERR2: HREADY=1, HRESP=ERROR. This cycle accepts the next address phase. Next state is ERR1 if that phase is again an unselected NONSEQ/SEQ, otherwise IDLE.
  - IDLE or BUSY to an unmapped address: zero-wait OKAY, no error, no count.
- ERR_CNT:
  - Increments by 1 on each IDLE→ERR1 or ERR2→ERR1 transition.
  - Saturates at all-ones.
  - ERR_CLR=1 forces 0 and takes priority over a same-cycle increment.
- HRESP values 10/11 (RETRY/SPLIT) from a slave are passed through unmodified.

## Timing
- Reset (HRESETn=0, asynchronous) sets dsel=DEFAULT, FSM=IDLE and ERR_CNT=0. Outputs during reset: HREADY=1, HRESP=00, HRDATA=0, ERR_CNT=0.
- Reset mid-error (in ERR1 or ERR2) returns immediately to IDLE with OKAY. ERR_CNT clears.
- No added latency: the select registered at edge N drives the mux for the whole data phase starting at N.
- While the selected slave holds HREADYOUT=0, dsel holds. Address-phase HSEL inputs are ignored until HREADY=1.
- Error response is exactly 2 cycles (ERR1 then ERR2). Back-to-back errors give the pattern ERR1, ERR2, ERR1, ERR2 with no OKAY gap.

## Test plan
- Reset: hold HRESETn=0 with random inputs → HREADY=1, HRESP=00, HRDATA=0, ERR_CNT=0. Release, then drive HTRANS=IDLE → outputs unchanged.
- RISC read: HSEL_RISC=1, HTRANS=10, then HRDATA_RISC=0xDEADBEEF with HREADYOUT_RISC=0 for 2 cycles then 1.
  - Response: HREADY low for 2 cycles, then HRDATA=0xDEADBEEF with HREADY=1 and HRESP=00.
  - Check that a new HSEL_ADDER presented during the wait is not captured.
- Pipelined switch: NONSEQ to ADDER, then NONSEQ to RISC back-to-back → first data phase shows HRDATA_ADDER, next shows HRDATA_RISC, each with zero wait.
- Decode error: HSEL_RISC=HSEL_ADDER=0, HTRANS=10 → next cycle HREADY=0/HRESP=01, following cycle HREADY=1/HRESP=01, then OKAY. ERR_CNT=1.
- Back-to-back errors and saturation:
  - Three consecutive unmapped NONSEQs → ERR1, ERR2 repeated ×3, ERR_CNT=3.
  - Unmapped IDLE/BUSY → OKAY, no count change.
  - With ECNT_W=2, five errors → ERR_CNT=3.
  - ERR_CLR asserted on an increment cycle → ERR_CNT=0.
- Reset during ERR1: assert HRESETn=0 mid-error → HREADY=1 and HRESP=00 immediately (asynchronously). After release, the FSM is in IDLE.

Source files
------------

// File: rtl/ahb_slave_mux_if.sv
// rtl/ahb_slave_mux_if.sv - bus bundle between decoder/slaves, the slave mux and the master
//
// Purpose: groups the address-phase selects, the per-slave responses, the
// muxed response returned to the master and the decode-error counter.
// Modports:
//   slave  - seen by ahb_slave_mux (selects/slave responses/ERR_CLR in,
//            muxed HRDATA/HREADY/HRESP and ERR_CNT out)
//   master - seen by whatever drives the selects and consumes the response
interface ahb_slave_mux_if #(
    parameter int DATA_W = 32,
    parameter int ECNT_W = 8
);
    logic              HSEL_RISC;
    logic              HSEL_ADDER;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HRDATA_RISC;
    logic              HREADYOUT_RISC;
    logic [1:0]        HRESP_RISC;
    logic [DATA_W-1:0] HRDATA_ADDER;
    logic              HREADYOUT_ADDER;
    logic [1:0]        HRESP_ADDER;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [ECNT_W-1:0] ERR_CNT;
    logic              ERR_CLR;

    modport slave (
        input  HSEL_RISC, HSEL_ADDER, HTRANS,
        input  HRDATA_RISC, HREADYOUT_RISC, HRESP_RISC,
        input  HRDATA_ADDER, HREADYOUT_ADDER, HRESP_ADDER,
        input  ERR_CLR,
        output HRDATA, HREADY, HRESP, ERR_CNT
    );

    modport master (
        output HSEL_RISC, HSEL_ADDER, HTRANS,
        output HRDATA_RISC, HREADYOUT_RISC, HRESP_RISC,
        output HRDATA_ADDER, HREADYOUT_ADDER, HRESP_ADDER,
        output ERR_CLR,
        input  HRDATA, HREADY, HRESP, ERR_CNT
    );
endinterface

// File: rtl/ahb_slave_mux.sv
// rtl/ahb_slave_mux.sv - AHB read-response mux with built-in default (error) slave
//
// Purpose: registers the decoder's address-phase selects into a one-hot
// data-phase select and routes the chosen slave's HRDATA/HREADYOUT/HRESP back
// to the master. Unmapped NONSEQ/SEQ transfers are answered by a default
// slave with the two-cycle ERROR response; each such error bumps a
// saturating debug counter.
// Ports:
//   HCLK    - bus clock, all state updates on the rising edge
//   HRESETn - asynchronous active-low reset
//   bus     - ahb_slave_mux_if.slave (selects, slave responses, ERR_CLR in;
//             HRDATA/HREADY/HRESP/ERR_CNT out)
module ahb_slave_mux #(
    parameter int DATA_W = 32,
    parameter int ECNT_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_slave_mux_if.slave    bus
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // One-hot data-phase select.
    localparam logic [2:0] DSEL_RISC    = 3'b001;
    localparam logic [2:0] DSEL_ADDER   = 3'b010;
    localparam logic [2:0] DSEL_DEFAULT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } dflt_state_t;

    logic [2:0]        dsel;
    logic [2:0]        dsel_next;
    dflt_state_t       state;
    dflt_state_t       state_next;
    logic              dflt_ready;
    logic [1:0]        dflt_resp;
    logic              hready;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic              unmapped_xfer;
    logic              err_inc;
    logic [ECNT_W-1:0] err_cnt;

    // Address-phase decode; RISC has priority when both selects are high.
    always_comb begin
        dsel_next = DSEL_DEFAULT;
        if (bus.HSEL_RISC) begin
            dsel_next = DSEL_RISC;
        end else if (bus.HSEL_ADDER) begin
            dsel_next = DSEL_ADDER;
        end
    end

    // The select only advances when the bus accepts an address phase, so a
    // waiting slave keeps ownership of the response path.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= DSEL_DEFAULT;
        end else if (hready) begin
            dsel <= dsel_next;
        end
    end

    // An accepted NONSEQ/SEQ that no slave claims. IDLE/BUSY to an unmapped
    // address is answered with a zero-wait OKAY and never reaches here.
    assign unmapped_xfer = hready && (dsel_next == DSEL_DEFAULT) && bus.HTRANS[1];

    // Default-slave FSM: state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Default-slave FSM: next state. ERR2 is the accepting cycle of the error
    // response, so a following unmapped transfer re-enters ERR1 directly.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = unmapped_xfer ? ST_ERR1 : ST_IDLE;
            ST_ERR1: state_next = ST_ERR2;
            ST_ERR2: state_next = unmapped_xfer ? ST_ERR1 : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Default-slave FSM: outputs.
    always_comb begin
        dflt_ready = 1'b1;
        dflt_resp  = RESP_OKAY;
        case (state)
            ST_IDLE: begin
                dflt_ready = 1'b1;
                dflt_resp  = RESP_OKAY;
            end
            ST_ERR1: begin
                dflt_ready = 1'b0;
                dflt_resp  = RESP_ERROR;
            end
            ST_ERR2: begin
                dflt_ready = 1'b1;
                dflt_resp  = RESP_ERROR;
            end
            default: begin
                dflt_ready = 1'b1;
                dflt_resp  = RESP_OKAY;
            end
        endcase
    end

    // Response mux. Slave responses (including RETRY/SPLIT) pass through
    // untouched; the default slave never returns read data.
    always_comb begin
        hrdata = '0;
        hready = dflt_ready;
        hresp  = dflt_resp;
        case (dsel)
            DSEL_RISC: begin
                hrdata = bus.HRDATA_RISC;
                hready = bus.HREADYOUT_RISC;
                hresp  = bus.HRESP_RISC;
            end
            DSEL_ADDER: begin
                hrdata = bus.HRDATA_ADDER;
                hready = bus.HREADYOUT_ADDER;
                hresp  = bus.HRESP_ADDER;
            end
            default: begin
                hrdata = '0;
                hready = dflt_ready;
                hresp  = dflt_resp;
            end
        endcase
    end

    // Every entry into ERR1 marks one new decode error.
    assign err_inc = (state_next == ST_ERR1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_cnt <= '0;
        end else if (bus.ERR_CLR) begin
            err_cnt <= '0;
        end else if (err_inc && !(&err_cnt)) begin
            err_cnt <= err_cnt + ECNT_W'(1);
        end
    end

    assign bus.HRDATA  = hrdata;
    assign bus.HREADY  = hready;
    assign bus.HRESP   = hresp;
    assign bus.ERR_CNT = err_cnt;

endmodule
